// File: rtl/hazard_pkg.sv
// Shared types for the hazard control unit: FSM state encoding and register x0 index.
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] X0 = 5'd0;
endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive data-memory wait cycles; expired flags the final allowed cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + W'(1);
  end

  assign expired = (cnt == LAST);
endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control: memory stalls with timeout, branch flush, load-use interlock.
// Optional perf counter of stall_pc cycles enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [4:0]  rd_ex,
  input  logic        memRead_ex,
  input  logic        branchTaken_ex,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        mem_err
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);
  state_t state, state_nxt;
  logic   timer_clr, timer_en, timer_expired;
  logic   mem_stall, load_use;

  assign mem_stall = dmem_req && !dmem_ready;
  assign load_use  = memRead_ex && (rd_ex != X0) &&
                     ((rd_ex == rs1_id) || (rd_ex == rs2_id));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    timer_clr   = 1'b1;
    timer_en    = 1'b0;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    mem_err     = 1'b0;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          {stall_pc, stall_ifid, stall_idex, stall_exmem} = 4'b1111;
          if (state == MEM_WAIT) begin
            timer_clr = 1'b0;
            timer_en  = 1'b1;
            state_nxt = timer_expired ? ERROR : MEM_WAIT;
          end else begin
            state_nxt = MEM_WAIT;
          end
        end else begin
          // Branch wins over load-use: the ID instruction is being discarded anyway.
          state_nxt = RUN;
          if (branchTaken_ex) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (load_use) begin
            stall_pc   = 1'b1;
            stall_ifid = 1'b1;
            flush_idex = 1'b1;
          end
        end
      end
      ERROR: begin
        {stall_pc, stall_ifid, stall_idex, stall_exmem} = 4'b1111;
        mem_err = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clr),
    .enable  (timer_en),
    .expired (timer_expired)
  );

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  stall_cycles <= '0;
    else if (stall_pc && (stall_cycles != '1))   stall_cycles <= stall_cycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: default-timeout instance for hazard scenarios, MEM_TIMEOUT=4 instance for timeout/reset.
module tb_hazard_control_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_id, rs2_id, rd_ex;
  logic       memRead_ex, branchTaken_ex, dmem_req, dmem_ready;

  logic a_spc, a_sif, a_sid, a_sem, a_fif, a_fid, a_err;
  logic b_spc, b_sif, b_sid, b_sem, b_fif, b_fid, b_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] a_cnt, b_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_control_unit u_a (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .memRead_ex(memRead_ex), .branchTaken_ex(branchTaken_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(a_spc), .stall_ifid(a_sif), .stall_idex(a_sid), .stall_exmem(a_sem),
    .flush_ifid(a_fif), .flush_idex(a_fid), .mem_err(a_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(a_cnt)
`endif
  );

  hazard_control_unit #(.MEM_TIMEOUT(4)) u_b (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_ex(rd_ex),
    .memRead_ex(memRead_ex), .branchTaken_ex(branchTaken_ex),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stall_pc(b_spc), .stall_ifid(b_sif), .stall_idex(b_sid), .stall_exmem(b_sem),
    .flush_ifid(b_fif), .flush_idex(b_fid), .mem_err(b_err)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cycles(b_cnt)
`endif
  );

  // {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, mem_err}
  wire [6:0] out_a = {a_spc, a_sif, a_sid, a_sem, a_fif, a_fid, a_err};
  wire [6:0] out_b = {b_spc, b_sif, b_sid, b_sem, b_fif, b_fid, b_err};

  localparam logic [6:0] NONE   = 7'b0000000;
  localparam logic [6:0] LDUSE  = 7'b1100010;
  localparam logic [6:0] BRANCH = 7'b0000110;
  localparam logic [6:0] MSTALL = 7'b1111000;
  localparam logic [6:0] ERR    = 7'b1111001;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs sampled 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic br, input logic rq, input logic rdy);
    memRead_ex = mr; rd_ex = rd; rs1_id = r1; rs2_id = r2;
    branchTaken_ex = br; dmem_req = rq; dmem_ready = rdy;
    #2;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("reset_a", {25'd0, out_a}, {25'd0, NONE});
    check("reset_b", {25'd0, out_b}, {25'd0, NONE});
`ifdef HAZARD_PERF_CNT_EN
    check("reset_cnt", a_cnt, 32'd0);
`endif
    next_cycle();
    rst_n = 1'b1;

    // Load-use on rs2, then rd_ex cleared
    drive(1, 5, 1, 5, 0, 0, 0);
    check("lduse_rs2", {25'd0, out_a}, {25'd0, LDUSE});
    next_cycle();
    drive(1, 0, 1, 5, 0, 0, 0);
    check("lduse_rd0_next", {25'd0, out_a}, {25'd0, NONE});
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0);
    check("x0_no_stall", {25'd0, out_a}, {25'd0, NONE});
    next_cycle();
    drive(1, 7, 7, 7, 0, 0, 0);
    check("lduse_both_rs", {25'd0, out_a}, {25'd0, LDUSE});
    next_cycle();
    drive(0, 7, 7, 7, 0, 0, 0);
    check("no_load_no_stall", {25'd0, out_a}, {25'd0, NONE});
    next_cycle();
    drive(1, 9, 3, 4, 0, 0, 0);
    check("load_no_match", {25'd0, out_a}, {25'd0, NONE});
    next_cycle();

    // Branch outranks load-use
    drive(1, 3, 3, 0, 1, 0, 0);
    check("branch_over_lduse", {25'd0, out_a}, {25'd0, BRANCH});
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 0);
    check("branch_alone", {25'd0, out_a}, {25'd0, BRANCH});
    next_cycle();

    // Memory stall 5 cycles; branch + load-use raised mid-wait are held off
    for (int i = 0; i < 5; i++) begin
      if (i >= 2) drive(1, 3, 3, 0, 1, 1, 0);
      else        drive(0, 0, 0, 0, 0, 1, 0);
      check($sformatf("mem_wait_%0d", i), {25'd0, out_a}, {25'd0, MSTALL});
      next_cycle();
    end
    drive(0, 0, 0, 0, 1, 1, 1);
    check("ready_serves_branch", {25'd0, out_a}, {25'd0, BRANCH});
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("back_to_run", {25'd0, out_a}, {25'd0, NONE});
    // A RUN state takes a fresh load-use immediately
    drive(1, 6, 6, 0, 0, 0, 0);
    check("run_after_wait", {25'd0, out_a}, {25'd0, LDUSE});
`ifdef HAZARD_PERF_CNT_EN
    // 1 (rs2 load-use) + 1 (dual-rs load-use) + 5 memory stall cycles so far
    check("perf_cnt", a_cnt, 32'd7);
`endif
    next_cycle();

    // Timeout instance: reset, then hold dmem_ready low
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    next_cycle();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0);
      check($sformatf("tmo_wait_%0d", i), {25'd0, out_b}, {25'd0, MSTALL});
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 1, 0);
    check("tmo_error", {25'd0, out_b}, {25'd0, ERR});
    next_cycle();
    drive(0, 0, 0, 0, 1, 0, 0);
    check("error_sticky", {25'd0, out_b}, {25'd0, ERR});
    // Asynchronous reset mid-cycle clears error at once
    rst_n = 1'b0;
    #1;
    check("async_rst_clears", {25'd0, out_b}, {25'd0, BRANCH});
    drive(0, 0, 0, 0, 0, 1, 0);
    check("rst_evaluates_run", {25'd0, out_b}, {25'd0, MSTALL});
    next_cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    check("post_rst_idle", {25'd0, out_b}, {25'd0, NONE});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
